// File: rtl/vote_result_reader.sv
// Result-mode readout: snapshots the four vote tallies, scans them for winner/tie/total,
// then drives the result LEDs. Build option: define RESULT_AUTOSCAN_EN to auto-cycle candidates in SHOW.
module vote_result_reader #(
    parameter int unsigned DISPLAY_CYCLES = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic [7:0] cand_1_vote,
    input  logic [7:0] cand_2_vote,
    input  logic [7:0] cand_3_vote,
    input  logic [7:0] cand_4_vote,
    input  logic [4:1] candidate_button,
    output logic [7:0] result_leds,
    output logic [4:1] shown_cand,
    output logic [4:1] winner,
    output logic       tie,
    output logic [9:0] total_votes,
    output logic       result_valid
);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        SHOW
    } state_t;

    state_t state, state_next;

    logic [7:0] snap [4];
    logic [1:0] scan_idx;
    logic [7:0] run_max;
    logic [1:0] run_leader;
    logic       run_tie;
    logic [9:0] run_total;

    logic [7:0] cur_vote;
    logic [7:0] max_nx;
    logic [1:0] leader_nx;
    logic       tie_nx;
    logic [9:0] total_nx;
    logic [1:0] btn_idx;

`ifdef RESULT_AUTOSCAN_EN
    localparam int unsigned DW = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;
    logic [DW-1:0] dwell;
    logic          manual;
    logic [1:0]    show_idx;
    logic [1:0]    show_nx;
`else
    logic [1:0]    entry_idx;
`endif

    generate
        if (DISPLAY_CYCLES == 0) begin : g_bad_cfg
            $error("DISPLAY_CYCLES must be at least 1");
        end
    endgenerate

    function automatic logic [3:0] one_hot(input logic [1:0] i);
        one_hot = 4'b0001 << i;
    endfunction

    function automatic logic [1:0] lowest_set(input logic [3:0] b);
        if (b[0])      lowest_set = 2'd0;
        else if (b[1]) lowest_set = 2'd1;
        else if (b[2]) lowest_set = 2'd2;
        else           lowest_set = 2'd3;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!mode) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_next = COMPARE;
                COMPARE: if (scan_idx == 2'd3) state_next = SHOW;
                SHOW:    state_next = SHOW;
                default: state_next = IDLE;
            endcase
        end
    end

    // One candidate per cycle; the final step's result feeds the output registers directly.
    always_comb begin
        cur_vote  = snap[scan_idx];
        max_nx    = run_max;
        leader_nx = run_leader;
        tie_nx    = run_tie;
        total_nx  = run_total + {2'b00, cur_vote};
        if (cur_vote > run_max) begin
            max_nx    = cur_vote;
            leader_nx = scan_idx;
            tie_nx    = 1'b0;
        end else if ((cur_vote == run_max) && (cur_vote != '0)) begin
            tie_nx = 1'b1;
        end
        btn_idx = lowest_set(candidate_button);
`ifdef RESULT_AUTOSCAN_EN
        show_nx = show_idx + 2'd1;
`else
        entry_idx = ((max_nx != '0) && !tie_nx) ? leader_nx : 2'd0;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset || !mode) begin
            result_leds  <= '0;
            shown_cand   <= '0;
            winner       <= '0;
            tie          <= 1'b0;
            total_votes  <= '0;
            result_valid <= 1'b0;
            scan_idx     <= '0;
`ifdef RESULT_AUTOSCAN_EN
            show_idx     <= '0;
            manual       <= 1'b0;
            dwell        <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    snap[0]    <= cand_1_vote;
                    snap[1]    <= cand_2_vote;
                    snap[2]    <= cand_3_vote;
                    snap[3]    <= cand_4_vote;
                    run_max    <= '0;
                    run_leader <= '0;
                    run_tie    <= 1'b0;
                    run_total  <= '0;
                    scan_idx   <= '0;
                end
                COMPARE: begin
                    run_max    <= max_nx;
                    run_leader <= leader_nx;
                    run_tie    <= tie_nx;
                    run_total  <= total_nx;
                    scan_idx   <= scan_idx + 2'd1;
                    if (scan_idx == 2'd3) begin
                        winner       <= ((max_nx != '0) && !tie_nx) ? one_hot(leader_nx) : '0;
                        tie          <= tie_nx;
                        total_votes  <= total_nx;
                        result_valid <= 1'b1;
`ifdef RESULT_AUTOSCAN_EN
                        show_idx     <= 2'd0;
                        shown_cand   <= 4'b0001;
                        result_leds  <= snap[0];
                        manual       <= 1'b0;
                        dwell        <= '0;
`else
                        shown_cand   <= one_hot(entry_idx);
                        result_leds  <= snap[entry_idx];
`endif
                    end
                end
                SHOW: begin
                    if (candidate_button != '0) begin
                        shown_cand  <= one_hot(btn_idx);
                        result_leds <= snap[btn_idx];
`ifdef RESULT_AUTOSCAN_EN
                        show_idx    <= btn_idx;
                        manual      <= 1'b1;
                    end else if (!manual) begin
                        if (dwell == DW'(DISPLAY_CYCLES - 1)) begin
                            dwell       <= '0;
                            show_idx    <= show_nx;
                            shown_cand  <= one_hot(show_nx);
                            result_leds <= snap[show_nx];
                        end else begin
                            dwell <= dwell + DW'(1);
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vote_result_reader.sv
// Self-checking bench for vote_result_reader: table vectors, corner sequences and
// randomized tallies/buttons against a behavioural model of the result rules.
module tb_vote_result_reader;

    localparam int unsigned DISP = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       mode;
    logic [7:0] c1, c2, c3, c4;
    logic [4:1] candidate_button;
    logic [7:0] result_leds;
    logic [4:1] shown_cand;
    logic [4:1] winner;
    logic       tie;
    logic [9:0] total_votes;
    logic       result_valid;

    vote_result_reader #(.DISPLAY_CYCLES(DISP)) dut (
        .clock            (clock),
        .reset            (reset),
        .mode             (mode),
        .cand_1_vote      (c1),
        .cand_2_vote      (c2),
        .cand_3_vote      (c3),
        .cand_4_vote      (c4),
        .candidate_button (candidate_button),
        .result_leds      (result_leds),
        .shown_cand       (shown_cand),
        .winner           (winner),
        .tie              (tie),
        .total_votes      (total_votes),
        .result_valid     (result_valid)
    );

    always #5 clock = ~clock;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int          snap_m [4];
    int          win_m;
    bit          tie_m;
    int          total_m;
    int          man_idx;
    int unsigned show_t;

    typedef struct packed {
        logic [7:0] a, b, c, d;
        logic [3:0] win;
        logic       t;
        logic [9:0] tot;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_tallies(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
        c1 = a; c2 = b; c3 = c; c4 = d;
        snap_m[0] = int'(a); snap_m[1] = int'(b);
        snap_m[2] = int'(c); snap_m[3] = int'(d);
    endtask

    // Winner is the unique holder of a nonzero maximum; tie when two or more hold it.
    task automatic model();
        int mx;
        int cnt;
        int at;
        mx = 0; cnt = 0; at = 0; total_m = 0;
        for (int i = 0; i < 4; i++) begin
            total_m += snap_m[i];
            if (snap_m[i] > mx) mx = snap_m[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (snap_m[i] == mx) begin
                cnt++;
                at = i;
            end
        end
        tie_m = (mx != 0) && (cnt > 1);
        win_m = ((mx != 0) && (cnt == 1)) ? at : -1;
    endtask

    function automatic int lowest(input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (b[i]) return i;
        return -1;
    endfunction

    function automatic int exp_shown();
        if (man_idx >= 0) return man_idx;
`ifdef RESULT_AUTOSCAN_EN
        return int'((show_t / DISP) % 4);
`else
        return (win_m >= 0) ? win_m : 0;
`endif
    endfunction

    task automatic check_display(input string tag);
        int e;
        e = exp_shown();
        check({tag, "_shown"}, 32'(shown_cand), 32'(1) << e);
        check({tag, "_leds"}, 32'(result_leds), 32'(snap_m[e]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_leds"},   32'(result_leds),  0);
        check({tag, "_shown"},  32'(shown_cand),   0);
        check({tag, "_winner"}, 32'(winner),       0);
        check({tag, "_tie"},    32'(tie),          0);
        check({tag, "_total"},  32'(total_votes),  0);
        check({tag, "_valid"},  32'(result_valid), 0);
    endtask

    // Called at the negedge just before edge k (first edge sampling mode=1 in IDLE).
    task automatic await_results(input logic [3:0] cmp_btn);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                c1 = 8'($urandom); c2 = 8'($urandom);
                c3 = 8'($urandom); c4 = 8'($urandom);
            end
            if (i == 2) candidate_button = cmp_btn;
            @(negedge clock);
            candidate_button = '0;
            check("latency_valid", 32'(result_valid), 0);
        end
        @(negedge clock);
        model();
        man_idx = -1;
        show_t  = 0;
        check("valid",  32'(result_valid), 1);
        check("winner", 32'(winner), (win_m >= 0) ? (32'(1) << win_m) : 0);
        check("tie",    32'(tie), 32'(tie_m));
        check("total",  32'(total_votes), 32'(total_m));
        check_display("entry");
    endtask

    task automatic enter(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input logic [3:0] cmp_btn);
        @(negedge clock);
        mode = 1'b0;
        set_tallies(a, b, c, d);
        @(negedge clock);
        check_zero("mode0");
        mode = 1'b1;
        await_results(cmp_btn);
    endtask

    task automatic show_step(input logic [3:0] b, input string tag);
        candidate_button = b;
        @(negedge clock);
        candidate_button = '0;
        show_t++;
        if (b != '0) man_idx = lowest(b);
        check_display(tag);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mode  = 1'b0;
        candidate_button = '0;
        set_tallies(8'd0, 8'd0, 8'd0, 8'd0);
        man_idx = -1;
        show_t  = 0;
        repeat (2) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;

        tbl[0] = '{8'd5,   8'd9,   8'd3,   8'd7,   4'b0010, 1'b0, 10'd24};
        tbl[1] = '{8'd4,   8'd9,   8'd9,   8'd1,   4'b0000, 1'b1, 10'd23};
        tbl[2] = '{8'd0,   8'd0,   8'd0,   8'd0,   4'b0000, 1'b0, 10'd0};
        tbl[3] = '{8'd255, 8'd255, 8'd255, 8'd255, 4'b0000, 1'b1, 10'd1020};

        for (int i = 0; i < 4; i++) begin
            enter(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, (i == 1) ? 4'b1000 : 4'b0000);
            check("tbl_winner", 32'(winner), 32'(tbl[i].win));
            check("tbl_tie",    32'(tie), 32'(tbl[i].t));
            check("tbl_total",  32'(total_votes), 32'(tbl[i].tot));
            for (int s = 0; s < 40; s++) show_step(4'b0000, "auto");
            show_step(4'b0110, "btn0110");
            for (int s = 0; s < 50; s++) show_step(4'b0000, "btn_hold");
        end

        // Reset while showing results, with mode still high.
        @(negedge clock);
        reset = 1'b1;
        set_tallies(8'd2, 8'd8, 8'd8, 8'd3);
        @(negedge clock);
        check_zero("reset_show");
        reset = 1'b0;
        await_results(4'b0000);
        for (int s = 0; s < 10; s++) show_step(4'b0000, "post_reset");

        // Abort mid-COMPARE, then re-entry must use a fresh snapshot.
        @(negedge clock);
        mode = 1'b0;
        set_tallies(8'd12, 8'd15, 8'd5, 8'd6);
        @(negedge clock);
        mode = 1'b1;
        @(negedge clock);
        @(negedge clock);
        mode = 1'b0;
        @(negedge clock);
        check_zero("abort");
        set_tallies(8'd20, 8'd15, 8'd5, 8'd6);
        mode = 1'b1;
        await_results(4'b0000);
        check("reentry_total",  32'(total_votes), 46);
        check("reentry_winner", 32'(winner), 1);
        for (int s = 0; s < 12; s++) show_step(4'b0000, "reentry");

        for (int r = 0; r < 30; r++) begin
            int unsigned hi;
            hi = (r % 2 == 1) ? 3 : 255;
            enter(8'($urandom_range(0, hi)), 8'($urandom_range(0, hi)),
                  8'($urandom_range(0, hi)), 8'($urandom_range(0, hi)),
                  4'($urandom_range(0, 15)));
            for (int s = 0; s < 30; s++) begin
                logic [3:0] b;
                b = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
                show_step(b, "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
